bus_xfer_seq: RTL and testbench



---
 rtl/bus_xfer_seq.sv | 146 ++++++++++++++
 tb/tb_bus_xfer_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_seq.sv
// Bus transfer sequencer: queued {src,dst} commands -> registered source/load enables, one driver at a time.
// Pop 1 cycle after push, load edge 2 cycles after pop; cmd_ready = !full; BUS_TURNAROUND_EN adds an idle cycle per transfer.
module bus_xfer_seq #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_src,
    input  logic [2:0] cmd_dst,
    output logic       eni,
    output logic       ena,
    output logic       enb,
    output logic       enc,
    output logic       lda,
    output logic       ldb,
    output logic       ldc,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [1:0] src;
        logic [2:0] dst;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_LOAD  = 2'd2
`ifdef BUS_TURNAROUND_EN
        , S_TURN = 2'd3
`endif
    } state_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    cmd_t          head;

    state_t state, state_nxt;
    cmd_t   cur, cur_nxt;
    logic   advance;
    logic   done_nxt, err_nxt;
    logic [3:0] en_q, en_nxt;
    logic [2:0] ld_q, ld_nxt;

    assign cmd_ready = rst_n && (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (count != '0) || (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{src: cmd_src, dst: cmd_dst};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        pop       = 1'b0;
        advance   = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        en_nxt    = 4'b0000;
        ld_nxt    = 3'b000;
        case (state)
            S_IDLE:  advance = 1'b1;
            S_DRIVE: state_nxt = S_LOAD;
            S_LOAD: begin
                done_nxt = 1'b1;
`ifdef BUS_TURNAROUND_EN
                state_nxt = S_TURN;
`else
                advance = 1'b1;
`endif
            end
`ifdef BUS_TURNAROUND_EN
            S_TURN:  advance = 1'b1;
`endif
            default: state_nxt = S_IDLE;
        endcase

        // An empty-mask command is consumed but never reaches the bus.
        if (advance) begin
            state_nxt = S_IDLE;
            if (count != '0) begin
                pop     = 1'b1;
                cur_nxt = head;
                if (head.dst != 3'b000)
                    state_nxt = S_DRIVE;
                else
                    err_nxt = 1'b1;
            end
        end

        if (state_nxt == S_DRIVE || state_nxt == S_LOAD)
            en_nxt = 4'b0001 << cur_nxt.src;
        if (state_nxt == S_LOAD)
            ld_nxt = cur_nxt.dst;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cur   <= '0;
            en_q  <= 4'b0000;
            ld_q  <= 3'b000;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            en_q  <= en_nxt;
            ld_q  <= ld_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    assign {enc, enb, ena, eni} = en_q;
    assign {ldc, ldb, lda}      = ld_q;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq with a behavioural tri-state bus / register file downstream.
module tb_bus_xfer_seq;

`ifdef BUS_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif
    localparam int PERIOD    = TURN_EN ? 3 : 2;
    localparam int FIRST_LOW = TURN_EN ? 5 : 6;

    logic       clk = 1'b0;
    logic       rst_n, cmd_valid, cmd_ready;
    logic [1:0] cmd_src;
    logic [2:0] cmd_dst;
    logic       eni, ena, enb, enc, lda, ldb, ldc, busy, done, err;
    logic [3:0] en;
    logic [2:0] ld;
    logic [7:0] in_data, ra, rb, rc, bus;

    int n_checks = 0;
    int n_pass   = 0;
    int onehot_viol = 0;
    int tight_switch = 0;
    int err_cnt = 0;
    logic [3:0] prev_en = 4'b0000;

    bus_xfer_seq #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .eni(eni), .ena(ena), .enb(enb), .enc(enc),
        .lda(lda), .ldb(ldb), .ldc(ldc),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign en  = {enc, enb, ena, eni};
    assign ld  = {ldc, ldb, lda};
    assign bus = eni ? in_data : ena ? ra : enb ? rb : enc ? rc : 8'h00;

    always @(posedge clk) begin
        if (!rst_n) begin
            ra <= 8'h00; rb <= 8'h00; rc <= 8'h00;
        end else begin
            if (lda) ra <= bus;
            if (ldb) rb <= bus;
            if (ldc) rc <= bus;
        end
    end

    always @(negedge clk) begin
        if ($countones(en) > 1) onehot_viol++;
        if (prev_en != 4'b0000 && en != 4'b0000 && prev_en != en) tight_switch++;
        prev_en = en;
        if (err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic [2:0] d);
        cmd_valid = 1'b1; cmd_src = s; cmd_dst = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_src = 2'd0; cmd_dst = 3'd0; in_data = 8'h00;
        tick(); tick();
        n_checks++; if (en !== 4'b0000) $display("FAIL reset_en: got %b want 0000", en); else n_pass++;
        n_checks++; if (ld !== 3'b000) $display("FAIL reset_ld: got %b want 000", ld); else n_pass++;
        n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, err}); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", cmd_ready); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready_release: got %b want 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_basic();
        in_data = 8'h5A;
        push(2'd0, 3'b001);
        n_checks++; if ({busy, en} !== 5'b1_0000) $display("FAIL basic_c0: got busy/en %b want 10000", {busy, en}); else n_pass++;
        tick();
        n_checks++; if ({en, ld} !== 7'b0001_000) $display("FAIL basic_drive: got en/ld %b want 0001000", {en, ld}); else n_pass++;
        tick();
        n_checks++; if ({en, ld} !== 7'b0001_001) $display("FAIL basic_load: got en/ld %b want 0001001", {en, ld}); else n_pass++;
        tick();
        n_checks++; if (ra !== 8'h5A) $display("FAIL basic_rega: got %h want 5a", ra); else n_pass++;
        n_checks++; if ({done, en, ld} !== 8'b1_0000_000) $display("FAIL basic_done: got done/en/ld %b want 10000000", {done, en, ld}); else n_pass++;
        n_checks++; if (busy !== TURN_EN) $display("FAIL basic_busy: got %b want %b", busy, TURN_EN); else n_pass++;
        tick();
        n_checks++; if ({done, busy} !== 2'b00) $display("FAIL basic_after: got done/busy %b want 00", {done, busy}); else n_pass++;
    endtask

    task automatic test_broadcast();
        bit ok;
        in_data = 8'hC3;
        push(2'd0, 3'b001);
        drain(ok);
        n_checks++; if (!ok || ra !== 8'hC3) $display("FAIL bcast_setup: got ok=%0b a=%h want 1/c3", ok, ra); else n_pass++;
        in_data = 8'h00;
        push(2'd1, 3'b110);
        n_checks++; if (en !== 4'b0000) $display("FAIL bcast_c0: got en %b want 0000", en); else n_pass++;
        tick();
        n_checks++; if ({en, ld} !== 7'b0010_000) $display("FAIL bcast_drive: got en/ld %b want 0010000", {en, ld}); else n_pass++;
        tick();
        n_checks++; if ({en, ld} !== 7'b0010_110) $display("FAIL bcast_load: got en/ld %b want 0010110", {en, ld}); else n_pass++;
        tick();
        n_checks++; if ({rb, rc} !== 16'hC3C3) $display("FAIL bcast_regs: got b=%h c=%h want c3/c3", rb, rc); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL bcast_done: got %b want 1", done); else n_pass++;
        drain(ok);
    endtask

    task automatic test_zero_dst();
        bit ok;
        int err0;
        err0 = err_cnt;
        in_data = 8'h3C;
        cmd_valid = 1'b1; cmd_src = 2'd0; cmd_dst = 3'b000;
        tick();
        cmd_dst = 3'b010;
        n_checks++; if (err !== 1'b0) $display("FAIL zero_c0_err: got %b want 0", err); else n_pass++;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if ({err, en, ld} !== 8'b1_0000_000) $display("FAIL zero_err_pulse: got err/en/ld %b want 10000000", {err, en, ld}); else n_pass++;
        tick();
        n_checks++; if ({err, en} !== 5'b0_0001) $display("FAIL zero_next_drive: got err/en %b want 00001", {err, en}); else n_pass++;
        tick();
        n_checks++; if (ld !== 3'b010) $display("FAIL zero_next_load: got %b want 010", ld); else n_pass++;
        tick();
        n_checks++; if ({done, rb} !== {1'b1, 8'h3C}) $display("FAIL zero_next_done: got done=%b b=%h want 1/3c", done, rb); else n_pass++;
        drain(ok);
        n_checks++; if (err_cnt - err0 !== 1) $display("FAIL zero_err_count: got %0d want 1", err_cnt - err0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        in_data = 8'h11;
        push(2'd0, 3'b010);
        drain(ok);
        n_checks++; if (!ok || rb !== 8'h11) $display("FAIL rstmid_setup: got ok=%0b b=%h want 1/11", ok, rb); else n_pass++;
        push(2'd1, 3'b010);
        tick(); tick();
        n_checks++; if ({en, ld} !== 7'b0010_010) $display("FAIL rstmid_in_load: got en/ld %b want 0010010", {en, ld}); else n_pass++;
        rst_n = 1'b0;
        cmd_valid = 1'b1; cmd_src = 2'd0; cmd_dst = 3'b001;
        tick();
        n_checks++; if ({en, ld} !== 7'b0000_000) $display("FAIL rstmid_enables: got %b want 0000000", {en, ld}); else n_pass++;
        n_checks++; if ({busy, done, cmd_ready} !== 3'b000) $display("FAIL rstmid_flags: got busy/done/rdy %b want 000", {busy, done, cmd_ready}); else n_pass++;
        tick();
        n_checks++; if ({busy, done, cmd_ready} !== 3'b000) $display("FAIL rstmid_hold: got busy/done/rdy %b want 000", {busy, done, cmd_ready}); else n_pass++;
        rst_n = 1'b1; cmd_valid = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_release: got %b want 1", cmd_ready); else n_pass++;
        tick();
        n_checks++; if ({busy, en} !== 5'b0_0000) $display("FAIL rstmid_empty: got busy/en %b want 00000", {busy, en}); else n_pass++;
    endtask

    task automatic test_fill();
        logic [2:0] pat [8];
        logic [2:0] got [8];
        int idx, nld, first_low;
        bit acc;
        pat = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111, 3'b001};
        idx = 0; nld = 0; first_low = -1;
        in_data = 8'h42;
        cmd_valid = 1'b1; cmd_src = 2'd0; cmd_dst = pat[0];
        for (int e = 0; e < 80; e++) begin
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 8) cmd_dst = pat[idx];
                else cmd_valid = 1'b0;
            end
            if (!cmd_ready && first_low < 0) first_low = e;
            if (ld != 3'b000) begin
                if (nld < 8) got[nld] = ld;
                nld++;
            end
            if (nld >= 8 && !busy) break;
        end
        cmd_valid = 1'b0;
        n_checks++; if (first_low !== FIRST_LOW) $display("FAIL fill_ready_drop: got edge %0d want %0d", first_low, FIRST_LOW); else n_pass++;
        n_checks++; if (idx !== 8) $display("FAIL fill_accepted: got %0d want 8", idx); else n_pass++;
        n_checks++; if (nld !== 8) $display("FAIL fill_loads: got %0d want 8", nld); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (i < nld && got[i] !== pat[i]) $display("FAIL fill_order%0d: got %b want %b", i, got[i], pat[i]);
            else if (i >= nld) $display("FAIL fill_order%0d: got none want %b", i, pat[i]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] srcs [3];
        logic [2:0] dsts [3];
        int dedge [3];
        int idx, nd;
        bit acc;
        srcs = '{2'd0, 2'd1, 2'd2};
        dsts = '{3'b001, 3'b010, 3'b100};
        idx = 0; nd = 0;
        in_data = 8'h77;
        cmd_valid = 1'b1; cmd_src = srcs[0]; cmd_dst = dsts[0];
        for (int e = 0; e < 60; e++) begin
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) begin cmd_src = srcs[idx]; cmd_dst = dsts[idx]; end
                else cmd_valid = 1'b0;
            end
            if (done) begin
                if (nd < 3) dedge[nd] = e;
                nd++;
            end
            if (nd >= 3 && !busy) break;
        end
        cmd_valid = 1'b0;
        n_checks++; if (nd !== 3) $display("FAIL b2b_count: got %0d want 3", nd); else n_pass++;
        n_checks++; if (nd >= 2 && dedge[1] - dedge[0] !== PERIOD) $display("FAIL b2b_period1: got %0d want %0d", dedge[1] - dedge[0], PERIOD); else if (nd >= 2) n_pass++;
        n_checks++; if (nd >= 3 && dedge[2] - dedge[1] !== PERIOD) $display("FAIL b2b_period2: got %0d want %0d", dedge[2] - dedge[1], PERIOD); else if (nd >= 3) n_pass++;
        n_checks++; if (rc !== 8'h77) $display("FAIL b2b_chain: got c=%h want 77", rc); else n_pass++;
        tick();
        n_checks++; if (onehot_viol !== 0) $display("FAIL onehot: got %0d violations want 0", onehot_viol); else n_pass++;
        n_checks++; if ((tight_switch != 0) !== !TURN_EN) $display("FAIL driver_gap: got %0d tight switches, turnaround=%0b", tight_switch, TURN_EN); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_broadcast();
        test_zero_dst();
        test_reset_mid();
        test_fill();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
